// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with PC register and IF/ID pipeline register.
//
// Purpose:
//   Holds the program counter, presents it combinationally to instruction
//   memory, and latches the returned instruction word together with PC+4
//   into the IF/ID register. It also counts the valid instructions that
//   have been latched.
//   Priority of controls: reset > branch_taken > flush > stall > normal.
//
// Ports:
//   clk          in   1   rising-edge clock for all state
//   rst_n        in   1   synchronous active-low reset
//   stall        in   1   hold PC and IF/ID register
//   flush        in   1   load a bubble into IF/ID (PC still advances unless stalled)
//   branch_taken in   1   redirect PC to branch_addr and load a bubble into IF/ID
//   branch_addr  in  32   redirect target, bits [1:0] ignored
//   imem_addr    out 32   byte address to instruction memory (equals PC)
//   imem_data    in  32   instruction word for imem_addr, combinational
//   if_id_instr  out 32   registered instruction
//   if_id_pc4    out 32   registered PC+4 of if_id_instr
//   if_id_valid  out  1   if_id_instr is a real fetched instruction
//   fetch_count  out 32   number of valid instructions latched (wraps)

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // Only the word index is stored, so PC[1:0] is zero by construction.
  logic [29:0] pc_word;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc        = {pc_word, 2'b00};
  // 32-bit add drops the carry, so 32'hFFFF_FFFC + 4 wraps to 0.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_word     <= RESET_PC[31:2];
      if_id_instr <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else if (branch_taken) begin
      // A redirect wins over stall: the PC moves even when the stage is held.
      pc_word     <= branch_addr[31:2];
      if_id_instr <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if (!stall) begin
        pc_word <= pc_plus4[31:2];
      end
      if_id_instr <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc_word     <= pc_plus4[31:2];
      if_id_instr <= imem_data;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Every cycle the bench model's expected post-edge state is pushed to a
// scoreboard queue. After the edge the entry is popped and compared against
// the DUT outputs. Directed scenarios also check literal values.

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0022_0000;
    if (a == 32'h4) return 32'h0064_0000;
    return a ^ 32'h5A00_0001;
  endfunction

  assign imem_data = mem_word(imem_addr);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, push model expectation, clock, pop and compare.
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic br, input logic [31:0] ba);
    exp_t e, g;
    logic [31:0] d;
    rst_n = r; stall = st; flush = fl; branch_taken = br; branch_addr = ba;
    d = mem_word(m_pc);
    if (!r) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    end else if (br) begin
      m_pc = {ba[31:2], 2'b00}; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (fl) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (!st) m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_instr = d; m_pc4 = m_pc + 32'd4; m_valid = 1; m_count = m_count + 32'd1;
      m_pc = m_pc + 32'd4;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.count = m_count;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    checks++;
    if (imem_addr !== g.addr) begin
      errors++; $display("FAIL sb_imem_addr: got %h expected %h", imem_addr, g.addr);
    end
    checks++;
    if (if_id_instr !== g.instr) begin
      errors++; $display("FAIL sb_if_id_instr: got %h expected %h", if_id_instr, g.instr);
    end
    checks++;
    if (if_id_pc4 !== g.pc4) begin
      errors++; $display("FAIL sb_if_id_pc4: got %h expected %h", if_id_pc4, g.pc4);
    end
    checks++;
    if (if_id_valid !== g.valid) begin
      errors++; $display("FAIL sb_if_id_valid: got %b expected %b", if_id_valid, g.valid);
    end
    checks++;
    if (fetch_count !== g.count) begin
      errors++; $display("FAIL sb_fetch_count: got %0d expected %0d", fetch_count, g.count);
    end
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 32'h0000_0040);
    checks++;
    if (imem_addr !== RESET_PC || if_id_valid !== 1'b0 || fetch_count !== 0) begin
      errors++; $display("FAIL reset_state: addr %h valid %b count %0d expected %h 0 0",
                         imem_addr, if_id_valid, fetch_count, RESET_PC);
    end
  endtask

  task automatic test_sequential;
    step(1, 0, 0, 0, 0);
    checks++;
    if (if_id_instr !== 32'h0022_0000 || if_id_pc4 !== 32'd4) begin
      errors++; $display("FAIL seq_edge1: instr %h pc4 %h expected 00220000 00000004",
                         if_id_instr, if_id_pc4);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (if_id_instr !== 32'h0064_0000 || if_id_pc4 !== 32'd8 ||
        fetch_count !== 32'd2 || imem_addr !== 32'd8) begin
      errors++; $display("FAIL seq_edge2: instr %h pc4 %h count %0d addr %h expected 00640000 8 2 8",
                         if_id_instr, if_id_pc4, fetch_count, imem_addr);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0);
      checks++;
      if (imem_addr !== 32'd8 || if_id_pc4 !== 32'd8 || fetch_count !== 32'd2) begin
        errors++; $display("FAIL stall_hold: addr %h pc4 %h count %0d expected 8 8 2",
                           imem_addr, if_id_pc4, fetch_count);
      end
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (if_id_pc4 !== 32'd12) begin
      errors++; $display("FAIL stall_release: pc4 %h expected 0000000c", if_id_pc4);
    end
  endtask

  task automatic test_branch_over_stall;
    step(1, 1, 0, 1, 32'h0000_0013);
    checks++;
    if (imem_addr !== 32'h10 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      errors++; $display("FAIL branch_stall: addr %h valid %b instr %h expected 10 0 0",
                         imem_addr, if_id_valid, if_id_instr);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (if_id_pc4 !== 32'h14 || if_id_instr !== (32'h10 ^ 32'h5A00_0001)) begin
      errors++; $display("FAIL branch_target_fetch: pc4 %h instr %h expected 14 5a000011",
                         if_id_pc4, if_id_instr);
    end
  endtask

  task automatic test_flush;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 32'd8 || fetch_count !== 32'd1) begin
      errors++; $display("FAIL flush_only: valid %b addr %h count %0d expected 0 8 1",
                         if_id_valid, imem_addr, fetch_count);
    end
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'd12) begin
      errors++; $display("FAIL flush_stall: valid %b instr %h addr %h expected 0 0 c",
                         if_id_valid, if_id_instr, imem_addr);
    end
  endtask

  task automatic test_wrap;
    step(1, 0, 0, 1, 32'hFFFF_FFFE);
    step(1, 0, 0, 0, 0);
    checks++;
    if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== (32'hFFFF_FFFC ^ 32'h5A00_0001)) begin
      errors++; $display("FAIL pc_wrap: pc4 %h addr %h instr %h expected 0 0 a5fffffd",
                         if_id_pc4, imem_addr, if_id_instr);
    end
  endtask

  task automatic test_midrun_reset;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    checks++;
    if (fetch_count !== 32'd5) begin
      errors++; $display("FAIL midrun_pre: count %0d expected 5", fetch_count);
    end
    step(0, 0, 0, 1, 32'h0000_0100);
    checks++;
    if (imem_addr !== RESET_PC || if_id_instr !== 0 || if_id_pc4 !== 0 ||
        if_id_valid !== 0 || fetch_count !== 0) begin
      errors++; $display("FAIL midrun_reset: addr %h instr %h pc4 %h valid %b count %0d expected all 0",
                         imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (if_id_pc4 !== RESET_PC + 32'd4 || if_id_valid !== 1'b1 || if_id_instr !== 32'h0022_0000) begin
      errors++; $display("FAIL first_after_reset: pc4 %h valid %b instr %h expected 4 1 00220000",
                         if_id_pc4, if_id_valid, if_id_instr);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), $urandom);
    end
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; branch_taken = 0; branch_addr = 0;
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_flush();
    test_wrap();
    test_midrun_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (word-aligned).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-005 SHALL have port flush  input  1  replace next IF/ID contents with a bubble.
REQ-006 SHALL have port branch_taken  input  1  redirect PC to branch_addr.
REQ-007 SHALL have port branch_addr  input  32  redirect target; bits [1:0] ignored.
REQ-008 SHALL have port imem_addr  output  32  byte address to instruction memory.
REQ-009 SHALL have port imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-010 SHALL have port if_id_instr  output  32  registered instruction.
REQ-011 SHALL have port if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-012 SHALL have port if_id_valid  output  1  if_id_instr is a real fetched instruction.
REQ-013 SHALL have port fetch_count  output  32  number of valid instructions latched into IF/ID.

Function
REQ-014 SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally, with zero added latency.
REQ-015 SHALL hold PC[1:0] at 2'b00 at all times; branch_addr is loaded as {branch_addr[31:2],2'b00}.
REQ-016 Normal cycle (no stall, flush, branch): SHALL set PC <= PC+4, if_id_instr <= imem_data, if_id_pc4 <= PC+4, if_id_valid <= 1, fetch_count <= fetch_count+1.
REQ-017 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000); fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-018 branch_taken=1: SHALL set PC <= aligned branch_addr and load a bubble into IF/ID (if_id_instr=0, if_id_pc4=0, if_id_valid=0); fetch_count unchanged.
REQ-019 flush=1 without branch_taken: SHALL load a bubble into IF/ID; PC SHALL advance by 4 unless stall=1, in which case PC holds.
REQ-020 stall=1 without branch_taken or flush: SHALL hold PC, if_id_instr, if_id_pc4, if_id_valid and fetch_count unchanged.
REQ-021 Priority SHALL be reset > branch_taken > flush > stall > normal; branch_taken with stall=1 still redirects PC.
REQ-022 A bubble SHALL be all-zero instruction word 32'h0000_0000.
REQ-023 The stage SHALL hold no state other than PC, IF/ID register and fetch_count; imem_data is sampled only at the rising edge.

Reset
REQ-024 When rst_n=0 at a rising edge: PC <= RESET_PC, if_id_instr <= 0, if_id_pc4 <= 0, if_id_valid <= 0, fetch_count <= 0, overriding all other inputs.
REQ-025 Reset asserted mid-stream SHALL discard any in-flight IF/ID contents and any pending branch in the same cycle.
REQ-026 First edge after rst_n rises with no stall, flush or branch: IF/ID SHALL latch the instruction at RESET_PC, with if_id_pc4=RESET_PC+4 and valid=1.

Verification
REQ-027 Sequential fetch: reset, memory model returns mem[0]=32'h0022_0000, mem[1]=32'h0064_0000 -> after edge 1: if_id_instr=32'h0022_0000, if_id_pc4=4; after edge 2: if_id_instr=32'h0064_0000, if_id_pc4=8, fetch_count=2, imem_addr=8.
REQ-028 Stall: with PC=8, hold stall=1 for 3 edges -> imem_addr stays 8, IF/ID and fetch_count unchanged; on release, next edge gives if_id_pc4=12.
REQ-029 Branch over stall: PC=12, branch_taken=1, stall=1, branch_addr=32'h0000_0013 -> PC=32'h10, if_id_valid=0, if_id_instr=0; next edge latches mem at 0x10 with if_id_pc4=32'h14.
REQ-030 Flush only: PC=4, flush=1 -> if_id_valid=0, PC=8, fetch_count unchanged; flush=1 with stall=1 -> bubble, PC holds.
REQ-031 Wrap: branch to 32'hFFFF_FFFC, then one normal edge -> if_id_pc4=0, PC=0.
REQ-032 Mid-run reset: after 5 fetches, rst_n=0 for one edge with branch_taken=1 -> PC=RESET_PC, all IF/ID outputs and fetch_count 0.
